halt_mem_dumper: RTL and testbench

Post-halt data-memory reader for the pipelined processor. Once the core signals halt (HALT opcode, 6'h11, reaches decode), the block walks a configurable window of data memory through a synchronous read port. It streams each word out as an (address, data) pair on a valid/ready interface, so a bench or host can collect final memory contents without hierarchical peeks. It sits beside the data memory, sharing its read port only after the core has stopped issuing accesses.

---
 rtl/halt_mem_dumper_pkg.sv | 16 +
 rtl/halt_mem_dumper.sv | 95 +++++++++
 tb/tb_halt_mem_dumper.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_mem_dumper_pkg.sv
// Shared processor definitions used by the post-halt memory dumper.
package halt_mem_dumper_pkg;

  // HALT opcode, also decoded by the core's instruction decoder
  localparam logic [5:0] HALT_OPCODE = 6'h11;

  // Dump sequencer states
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    OUT,
    DONE
  } dump_state_e;

endpackage

// File: rtl/halt_mem_dumper.sv
// Post-halt data-memory dumper: walks a word window of data memory through
// a synchronous read port and streams (addr, data, last) over valid/ready.
module halt_mem_dumper
  import halt_mem_dumper_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0,
  parameter int WORD_COUNT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done
);

  // One extra index bit so WORD_COUNT == 2**ADDR_WIDTH is representable
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0]         LAST_IDX = IW'(WORD_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  dump_state_e   state;
  logic [IW-1:0] idx;

  // Sequencer: IDLE -> (REQ -> CAP -> OUT)* -> DONE, all outputs registered.
  // mem_raddr steps by one per word, so wrap past the top of memory falls
  // out of the modulo add naturally and it doubles as the captured address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      mem_ren    <= 1'b0;
      mem_raddr  <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state     <= REQ;
            idx       <= '0;
            mem_ren   <= 1'b1;
            mem_raddr <= BASE;
            busy      <= 1'b1;
          end
        end
        REQ: begin
          mem_ren <= 1'b0;
          state   <= CAP;
        end
        CAP: begin
          dump_data  <= mem_rdata;
          dump_addr  <= mem_raddr;
          dump_last  <= (idx == LAST_IDX);
          dump_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          // hold the presented word until the consumer takes it
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx       <= idx + IW'(1);
              mem_ren   <= 1'b1;
              mem_raddr <= mem_raddr + ADDR_WIDTH'(1);
              state     <= REQ;
            end
          end
        end
        DONE: begin
          // terminal until reset; halt is ignored here
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_mem_dumper.sv
// Bench for halt_mem_dumper: a timestamp-based reference model checks every
// cycle; directed scenarios pin the model with literal expectations.
module tb_halt_mem_dumper;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int BASE = 14;
  localparam int WC   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          halt = 1'b0;
  logic          dump_ready = 1'b0;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [16];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  int            m_k      = 0;
  int            m_ref    = 0;
  logic [AW-1:0] m_raddr  = '0;

  // logs of observed DUT activity
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];
  bit            q_last [$];
  logic [AW-1:0] q_rd   [$];
  int            t_halt = 0;
  int            t_done = 0;
  bit            seen_done = 1'b0;

  halt_mem_dumper #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .WORD_COUNT(WC)
  ) u_dut (
    .clk(clk), .reset(reset), .halt(halt),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read data memory
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: after the halt-accept edge or a non-final handshake edge (m_ref),
  // the read is visible in cycle m_ref, the word is presented from m_ref+2
  // until taken; word k lives at (BASE+k) mod 16.
  always @(negedge clk) begin : cmp
    logic [AW-1:0] ea;
    bit er, ev;
    if (!reset) begin
      m_active  = 1'b0;
      m_done    = 1'b0;
      m_k       = 0;
      m_raddr   = '0;
      seen_done = 1'b0;
      chk("rst_ren",   64'(mem_ren),    64'(0));
      chk("rst_raddr", 64'(mem_raddr),  64'(0));
      chk("rst_valid", 64'(dump_valid), 64'(0));
      chk("rst_addr",  64'(dump_addr),  64'(0));
      chk("rst_data",  64'(dump_data),  64'(0));
      chk("rst_last",  64'(dump_last),  64'(0));
      chk("rst_busy",  64'(busy),       64'(0));
      chk("rst_done",  64'(done),       64'(0));
    end else begin
      ea = AW'(BASE + m_k);
      er = m_active && !m_done && (cyc == m_ref);
      ev = m_active && !m_done && (cyc >= m_ref + 2);
      if (er) m_raddr = ea;
      chk("ren",   64'(mem_ren),    64'(er));
      chk("valid", 64'(dump_valid), 64'(ev));
      chk("busy",  64'(busy),       64'(m_active && !m_done));
      chk("done",  64'(done),       64'(m_done));
      chk("raddr", 64'(mem_raddr),  64'(m_raddr));
      if (ev) begin
        chk("daddr", 64'(dump_addr), 64'(ea));
        chk("ddata", 64'(dump_data), 64'(mem[ea]));
        chk("dlast", 64'(dump_last), 64'(m_k == WC - 1));
      end
      if (mem_ren) q_rd.push_back(mem_raddr);
      if (dump_valid && dump_ready) begin
        q_addr.push_back(dump_addr);
        q_data.push_back(dump_data);
        q_last.push_back(dump_last);
      end
      if (done && !seen_done) begin
        seen_done = 1'b1;
        t_done    = cyc;
      end
      if (!m_active && halt) begin
        m_active = 1'b1;
        m_k      = 0;
        m_ref    = cyc + 1;
        t_halt   = cyc + 1;
      end else if (ev && dump_ready) begin
        if (m_k == WC - 1) m_done = 1'b1;
        else begin
          m_k++;
          m_ref = cyc + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic clr_log();
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    q_rd.delete();
  endtask

  task automatic load_basic();
    foreach (mem[i]) mem[i] = $urandom;
    mem[14] = 32'hA0;
    mem[15] = 32'hA1;
    mem[0]  = 32'hA2;
    mem[1]  = 32'hA3;
  endtask

  task automatic pulse_halt();
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
  endtask

  task automatic wait_done(input int lim, input bit rnd);
    int n = 0;
    while (!done && n < lim) begin
      step();
      n++;
      if (rnd) begin
        dump_ready = 1'($urandom_range(0, 1));
        halt       = 1'($urandom_range(0, 1));
      end
    end
    chk("done_in_time", 64'(done), 64'(1));
  endtask

  task automatic wait_beat(input int nb, input int lim);
    int n = 0;
    while (!(dump_valid && q_addr.size() == nb) && n < lim) begin
      step();
      n++;
    end
    chk("beat_presented", 64'(dump_valid && q_addr.size() == nb), 64'(1));
  endtask

  task automatic chk_basic_beats();
    logic [AW-1:0] la [4];
    logic [DW-1:0] ld [4];
    la = '{4'd14, 4'd15, 4'd0, 4'd1};
    ld = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    chk("n_beats", 64'(q_addr.size()), 64'(4));
    chk("n_reads", 64'(q_rd.size()), 64'(4));
    if (q_addr.size() == 4 && q_rd.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("lit_raddr", 64'(q_rd[i]),   64'(la[i]));
        chk("lit_addr",  64'(q_addr[i]), 64'(la[i]));
        chk("lit_data",  64'(q_data[i]), 64'(ld[i]));
        chk("lit_last",  64'(q_last[i]), 64'(i == 3));
      end
    end
  endtask

  initial begin
    // reset then idle
    repeat (2) step();
    reset = 1'b1;
    repeat (20) step();
    chk("idle_no_reads", 64'(q_rd.size()), 64'(0));

    // basic dump across the wrap point
    load_basic();
    clr_log();
    dump_ready = 1'b1;
    pulse_halt();
    wait_done(100, 1'b0);
    step();
    chk_basic_beats();
    chk("basic_latency", 64'(t_done - t_halt), 64'(12));

    // backpressure on beat 2
    do_reset();
    clr_log();
    load_basic();
    dump_ready = 1'b1;
    pulse_halt();
    wait_beat(1, 50);
    dump_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", 64'(dump_addr), 64'(15));
      chk("stall_data", 64'(dump_data), 64'(32'hA1));
    end
    dump_ready = 1'b1;
    wait_done(100, 1'b0);
    step();
    chk_basic_beats();
    chk("stall_latency", 64'(t_done - t_halt), 64'(17));

    // reset in the middle of beat 2
    do_reset();
    clr_log();
    load_basic();
    dump_ready = 1'b1;
    pulse_halt();
    wait_beat(1, 50);
    dump_ready = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 64'(dump_valid), 64'(0));
    chk("async_busy",  64'(busy),       64'(0));
    chk("async_ren",   64'(mem_ren),    64'(0));
    repeat (2) step();
    reset = 1'b1;
    repeat (5) step();
    chk("no_partial_hs", 64'(q_addr.size()), 64'(1));
    chk("stays_idle",    64'(busy),          64'(0));
    clr_log();
    dump_ready = 1'b1;
    pulse_halt();
    wait_done(100, 1'b0);
    step();
    chk_basic_beats();

    // halt held high through the dump and beyond
    do_reset();
    clr_log();
    halt = 1'b1;
    wait_done(100, 1'b0);
    repeat (10) step();
    chk("hold_beats", 64'(q_addr.size()), 64'(WC));
    chk("hold_reads", 64'(q_rd.size()),   64'(WC));
    chk("hold_done",  64'(done),          64'(1));
    halt = 1'b0;

    // randomized memory, ready and halt
    for (int it = 0; it < 8; it++) begin
      do_reset();
      clr_log();
      foreach (mem[i]) mem[i] = $urandom;
      halt = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      wait_done(400, 1'b1);
      repeat (3) step();
      chk("rnd_beats", 64'(q_addr.size()), 64'(WC));
    end
    halt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
